io_checker: RTL and testbench
=============================

IO_CHECKER -- requirements
Module: io_checker

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored output channels, range 1..16.
REQ-002 Parameter DATA_W, default 32: width of each channel, range 1..32.
REQ-003 Parameter TIMEOUT, default 2000: RUN-phase cycle budget before a verdict is forced, at least 1.
REQ-004 Parameter RST_HOLD, default 4: number of cycles the DUT reset is held after start, at least 1.
REQ-005 Parameter REPORT_INT, default 100: period in cycles of the progress tick, at least 1.
REQ-006 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_start  in  1  single-cycle start/restart request.
REQ-009 i_abort  in  1  returns the block to IDLE from any state.
REQ-010 i_vld  in  1  DUT activity strobe (instruction-valid).
REQ-011 i_data  in  NUM_CH*DATA_W  packed channel values; channel k at bits [k*DATA_W +: DATA_W].
REQ-012 i_expect  in  NUM_CH*DATA_W  expected value per channel.
REQ-013 i_mask  in  NUM_CH*DATA_W  compare mask per channel; 1 = bit compared.
REQ-014 i_en  in  NUM_CH  channel enable; a disabled channel counts as satisfied.
REQ-015 o_dut_rst_n  out  1  generated active-low reset for the DUT.
REQ-016 o_busy  out  1  high in HOLD and RUN.
REQ-017 o_done  out  1  high in PASS and FAIL.
REQ-018 o_pass  out  1  high only in PASS.
REQ-019 o_fail_code  out  5  failure reason, valid in FAIL.
REQ-020 o_seen  out  NUM_CH  sticky per-channel match flags.
REQ-021 o_tick  out  1  one-cycle progress pulse.
REQ-022 o_cycles  out  32  RUN-phase cycle count.

Function
REQ-023 The FSM SHALL have the states IDLE, HOLD, RUN, PASS and FAIL.
REQ-024 In IDLE, an i_start SHALL clear the counters, o_seen and the vld-seen flag, then enter HOLD on the next edge.
REQ-025 In HOLD, o_dut_rst_n SHALL be 0 for exactly RST_HOLD cycles, then the FSM SHALL enter RUN; o_dut_rst_n is 1 in every other state.
REQ-026 In RUN, o_cycles SHALL increment by 1 per cycle, starting at 0 on the first RUN cycle and saturating at 2^32-1.
REQ-027 o_seen[k] SHALL set, sticky, in RUN when ((i_data_k ^ i_expect_k) & i_mask_k) == 0; an all-zero mask matches immediately.
REQ-028 The internal vld-seen flag SHALL set, sticky, on any RUN cycle with i_vld=1.
REQ-029 o_tick SHALL pulse in RUN when o_cycles mod REPORT_INT == 0, including cycle 0.
REQ-030 In RUN, the FSM SHALL go to PASS on the first edge where vld-seen and, for every channel, (o_seen[k] | ~i_en[k]) hold, counting matches registered on that same edge.
REQ-031 When o_cycles == TIMEOUT-1 in RUN without the pass condition, the FSM SHALL go to FAIL; a match on that final cycle SHALL still give PASS.
REQ-032 o_fail_code SHALL be 0 if vld-seen is never set, otherwise k+1 for the lowest enabled unseen channel k.
REQ-033 i_start in HOLD or RUN SHALL be ignored; in PASS or FAIL it SHALL restart exactly as from IDLE.
REQ-034 i_abort SHALL take priority over i_start and all transitions, giving IDLE on the next edge with o_seen and o_cycles retained.
REQ-035 o_seen, o_cycles and o_fail_code SHALL hold their values in PASS, FAIL and IDLE.

Reset
REQ-036 Asserting i_rst_n low SHALL immediately force: state IDLE; o_dut_rst_n=0; o_busy, o_done, o_pass and o_tick =0; o_fail_code=0; o_seen=0; o_cycles=0.
REQ-037 In IDLE after reset, o_dut_rst_n SHALL stay 0 until the first i_start completes HOLD.
REQ-038 Reset asserted mid-RUN SHALL discard the run with no verdict produced.

Structure
REQ-039 A package io_checker_pkg SHALL hold the state enum, the 5-bit fail-code type and the FAIL_NO_VLD=0 constant.
REQ-040 A sub-module io_checker_chan SHALL implement one masked-compare plus sticky flag, instantiated NUM_CH times by generate.

Verification
REQ-041 Defaults; i_vld at RUN cycle 3; ch0 reaches 0x1 at cycle 10; ch1 reaches 0x2 at cycle 20 -> PASS at cycle 20, o_seen=2'b11.
REQ-042 i_vld never asserted, both channels match -> FAIL at cycle 1999, o_fail_code=0.
REQ-043 ch1 never matches -> FAIL, o_fail_code=2; ch1 disabled instead -> PASS.
REQ-044 After start -> o_dut_rst_n=0 for exactly 4 cycles, o_tick at cycles 0, 100, 200.
REQ-045 i_abort at cycle 50 together with i_start -> IDLE, o_cycles=50; i_rst_n low mid-RUN -> all outputs at reset values the same cycle.
REQ-046 ch0 match first appears on cycle 1999 -> PASS, not FAIL.

Source files
------------

// File: rtl/io_checker_pkg.sv
// Shared types and constants for the io_checker block: FSM state
// encoding, the failure-code type and cycle-counter width.
package io_checker_pkg;

    localparam int unsigned CYCLE_W     = 32;
    localparam int unsigned FAIL_CODE_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    typedef logic [FAIL_CODE_W-1:0] fail_code_t;

    // Verdict code used when the DUT never showed any activity.
    localparam fail_code_t FAIL_NO_VLD = 5'd0;

endpackage : io_checker_pkg

// File: rtl/io_checker_chan.sv
// One monitored channel: masked compare of data against expected value
// and a sticky "seen" flag.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear the sticky flag (start of a new run)
//   i_upd          : compare result may set the flag this cycle (RUN)
//   i_data/i_expect/i_mask : channel value, reference, compare mask
//   o_seen         : registered sticky match flag
//   o_seen_nxt_c   : combinational next value of o_seen
module io_checker_chan #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_upd,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_expect,
    input  logic [DATA_W-1:0] i_mask,
    output logic              o_seen,
    output logic              o_seen_nxt_c
);

    logic match_c;

    // An all-zero mask compares no bits and therefore always matches.
    assign match_c      = (((i_data ^ i_expect) & i_mask) == '0);
    assign o_seen_nxt_c = !i_clr && (o_seen || (i_upd && match_c));

    // Sticky flag register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seen <= 1'b0;
        end else begin
            o_seen <= o_seen_nxt_c;
        end
    end

endmodule : io_checker_chan

// File: rtl/io_checker.sv
// Run-and-check controller: holds a DUT in reset, lets it run, watches
// NUM_CH output channels for expected values and issues PASS/FAIL.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start / i_abort   : start/restart request, return-to-IDLE request
//   i_vld               : DUT activity strobe
//   i_data/i_expect/i_mask : packed per-channel value, reference, mask
//   i_en                : per-channel enable (disabled = satisfied)
//   o_dut_rst_n         : generated active-low DUT reset
//   o_busy/o_done/o_pass: HOLD|RUN, PASS|FAIL, PASS
//   o_fail_code         : 0 = no activity, else lowest failing channel + 1
//   o_seen              : sticky per-channel match flags
//   o_tick              : progress pulse every REPORT_INT RUN cycles
//   o_cycles            : RUN-phase cycle count
module io_checker
    import io_checker_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 2000,
    parameter int unsigned RST_HOLD   = 4,
    parameter int unsigned REPORT_INT = 100
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_vld,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH*DATA_W-1:0] i_expect,
    input  logic [NUM_CH*DATA_W-1:0] i_mask,
    input  logic [NUM_CH-1:0]        i_en,
    output logic                     o_dut_rst_n,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [FAIL_CODE_W-1:0]   o_fail_code,
    output logic [NUM_CH-1:0]        o_seen,
    output logic                     o_tick,
    output logic [CYCLE_W-1:0]       o_cycles
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned REP_W  = (REPORT_INT > 1) ? $clog2(REPORT_INT) : 1;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                vld_seen_q, vld_seen_d;
    logic [CYCLE_W-1:0]  cycles_d;
    fail_code_t          fail_code_d, code_c;
    logic                dut_rst_n_d, busy_d, done_d, pass_d, tick_d;
    logic                clr_c, upd_c, vld_now_c, all_ok_c;
    logic [NUM_CH-1:0]   seen_nxt_c;

    // Per-channel masked compare with sticky flag.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        io_checker_chan #(
            .DATA_W (DATA_W)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_clr        (clr_c),
            .i_upd        (upd_c),
            .i_data       (i_data[k*DATA_W +: DATA_W]),
            .i_expect     (i_expect[k*DATA_W +: DATA_W]),
            .i_mask       (i_mask[k*DATA_W +: DATA_W]),
            .o_seen       (o_seen[k]),
            .o_seen_nxt_c (seen_nxt_c[k])
        );
    end

    // Pass condition sees this cycle's activity and matches.
    assign vld_now_c = vld_seen_q || i_vld;
    assign all_ok_c  = &(seen_nxt_c | ~i_en);

    // Failure reason: lowest enabled channel still unmatched.
    always_comb begin : fail_code_sel
        code_c = FAIL_NO_VLD;
        if (vld_now_c) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (i_en[k] && !seen_nxt_c[k]) begin
                    code_c = fail_code_t'(k + 1);
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_sel
        state_d     = state_q;
        hold_d      = hold_q;
        rep_d       = rep_q;
        vld_seen_d  = vld_seen_q;
        cycles_d    = o_cycles;
        fail_code_d = o_fail_code;
        dut_rst_n_d = o_dut_rst_n;
        clr_c       = 1'b0;
        upd_c       = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (i_start) begin
                        state_d     = ST_HOLD;
                        clr_c       = 1'b1;
                        hold_d      = '0;
                        rep_d       = '0;
                        vld_seen_d  = 1'b0;
                        cycles_d    = '0;
                        dut_rst_n_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                        state_d     = ST_RUN;
                        dut_rst_n_d = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    upd_c      = 1'b1;
                    vld_seen_d = vld_now_c;
                    if (vld_now_c && all_ok_c) begin
                        state_d = ST_PASS;
                    end else if (o_cycles == CYCLE_W'(TIMEOUT - 1)) begin
                        state_d     = ST_FAIL;
                        fail_code_d = code_c;
                    end else begin
                        cycles_d = (o_cycles == '1) ? o_cycles : o_cycles + CYCLE_W'(1);
                        rep_d    = (rep_q == REP_W'(REPORT_INT - 1)) ? '0 : rep_q + REP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_HOLD) || (state_d == ST_RUN);
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d = (state_d == ST_PASS);
        tick_d = (state_d == ST_RUN) && (rep_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            rep_q       <= '0;
            vld_seen_q  <= 1'b0;
            o_cycles    <= '0;
            o_fail_code <= FAIL_NO_VLD;
            o_dut_rst_n <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_tick      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            vld_seen_q  <= vld_seen_d;
            o_cycles    <= cycles_d;
            o_fail_code <= fail_code_d;
            o_dut_rst_n <= dut_rst_n_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_pass      <= pass_d;
            o_tick      <= tick_d;
        end
    end

endmodule : io_checker

// File: tb/tb_io_checker.sv
// Self-checking bench for io_checker: table of directed run scenarios,
// hand-written abort / mid-run reset sequences, and randomized runs
// checked against a first-match-cycle reference model.
module tb_io_checker;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 32;
    localparam int TIMEOUT    = 2000;
    localparam int RST_HOLD   = 4;
    localparam int REPORT_INT = 100;
    localparam int NEVER      = 1000000;

    logic                     i_clk;
    logic                     i_rst_n;
    logic                     i_start;
    logic                     i_abort;
    logic                     i_vld;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic [NUM_CH*DATA_W-1:0] i_expect;
    logic [NUM_CH*DATA_W-1:0] i_mask;
    logic [NUM_CH-1:0]        i_en;
    logic                     o_dut_rst_n;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_pass;
    logic [4:0]               o_fail_code;
    logic [NUM_CH-1:0]        o_seen;
    logic                     o_tick;
    logic [31:0]              o_cycles;

    io_checker #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .TIMEOUT    (TIMEOUT),
        .RST_HOLD   (RST_HOLD),
        .REPORT_INT (REPORT_INT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_vld       (i_vld),
        .i_data      (i_data),
        .i_expect    (i_expect),
        .i_mask      (i_mask),
        .i_en        (i_en),
        .o_dut_rst_n (o_dut_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_fail_code (o_fail_code),
        .o_seen      (o_seen),
        .o_tick      (o_tick),
        .o_cycles    (o_cycles)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Current stimulus plan: first vld cycle and first-match cycle per channel.
    int                p_v;
    int                p_t   [NUM_CH];
    logic [DATA_W-1:0] p_exp [NUM_CH];
    logic [DATA_W-1:0] p_msk [NUM_CH];

    typedef struct {
        int         v;
        int         t0;
        int         t1;
        logic [1:0] en;
        bit         zm0;
        bit         pass;
        int         cyc;
        logic [4:0] code;
        logic [1:0] seen;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // c < 0 means HOLD phase: drive matching data and vld to prove RUN gating.
    task automatic drive_inputs(input int c);
        i_vld   = (c < 0) ? 1'b1 : ((c == p_v) || ((c > p_v) && ($urandom_range(0, 3) == 0)));
        i_start = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < NUM_CH; k++) begin
            logic [DATA_W-1:0] lb;
            logic [DATA_W-1:0] noise;
            lb    = p_msk[k] & (~p_msk[k] + 32'd1);
            noise = $urandom & ~p_msk[k];
            i_expect[k*DATA_W +: DATA_W] = p_exp[k];
            i_mask[k*DATA_W +: DATA_W]   = p_msk[k];
            if ((c < 0) || (c >= p_t[k]))
                i_data[k*DATA_W +: DATA_W] = p_exp[k] ^ noise;
            else
                i_data[k*DATA_W +: DATA_W] = p_exp[k] ^ lb ^ noise;
        end
    endtask

    task automatic set_plan(input int v, input int t0, input int t1, input logic [1:0] en, input bit zm0);
        p_v      = v;
        p_t[0]   = zm0 ? 0 : t0;
        p_t[1]   = t1;
        p_exp[0] = $urandom;
        p_exp[1] = $urandom;
        p_msk[0] = zm0 ? '0 : ($urandom | 32'h1);
        p_msk[1] = $urandom | 32'h8000_0000;
        i_en     = en;
    endtask

    task automatic start_run();
        i_abort = 1'b0;
        drive_inputs(-1);
        i_start = 1'b1;
        step();
        for (int h = 0; h < RST_HOLD; h++) begin
            chk("hold_dut_rst", 32'(o_dut_rst_n), 32'd0);
            chk("hold_busy", 32'(o_busy), 32'd1);
            chk("hold_tick", 32'(o_tick), 32'd0);
            if (h == 0) begin
                chk("start_clr_cycles", o_cycles, 32'd0);
                chk("start_clr_seen", 32'(o_seen), 32'd0);
            end
            drive_inputs(-1);
            step();
        end
    endtask

    // Advance RUN cycles until a verdict or until stop_at is the current cycle.
    task automatic run_to(input int stop_at, output int c_end, output bit got_done);
        got_done = 1'b0;
        c_end    = stop_at;
        for (int c = 0; c < stop_at; c++) begin
            if (c == 0) chk("run_dut_rst", 32'(o_dut_rst_n), 32'd1);
            chk("run_cycles", o_cycles, 32'(c));
            chk("run_tick", 32'(o_tick), 32'((c % REPORT_INT) == 0));
            drive_inputs(c);
            step();
            if (o_done) begin
                got_done = 1'b1;
                c_end    = c;
                i_start  = 1'b0;
                i_vld    = 1'b0;
                return;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic finish_check(input string tag, input bit exp_pass, input int exp_cyc,
                                input logic [4:0] exp_code, input logic [1:0] exp_seen,
                                input int c_end, input bit got_done);
        if (!got_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s verdict_timeout got=none exp=verdict", tag);
            return;
        end
        chk({tag, "_pass"}, 32'(o_pass), 32'(exp_pass));
        chk({tag, "_cycles"}, o_cycles, 32'(exp_cyc));
        chk({tag, "_verdict_cycle"}, 32'(c_end), 32'(exp_cyc));
        chk({tag, "_seen"}, 32'(o_seen), 32'(exp_seen));
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        if (!exp_pass) chk({tag, "_code"}, 32'(o_fail_code), 32'(exp_code));
        step();
        chk({tag, "_hold_done"}, 32'(o_done), 32'd1);
        chk({tag, "_hold_cycles"}, o_cycles, 32'(exp_cyc));
        chk({tag, "_hold_dut_rst"}, 32'(o_dut_rst_n), 32'd1);
    endtask

    // Verdict from first-activity / first-match cycles alone.
    task automatic model(input int v, input int t0, input int t1, input logic [1:0] en,
                         output bit pass, output int cyc, output logic [4:0] code,
                         output logic [1:0] seen);
        int t [NUM_CH];
        int vc;
        t[0] = t0;
        t[1] = t1;
        vc   = v;
        for (int k = 0; k < NUM_CH; k++)
            if (en[k] && (t[k] > vc)) vc = t[k];
        pass = (vc <= TIMEOUT - 1);
        cyc  = pass ? vc : TIMEOUT - 1;
        code = 5'd0;
        for (int k = 0; k < NUM_CH; k++) seen[k] = (t[k] <= cyc);
        if (!pass && (v <= cyc)) begin
            for (int k = NUM_CH - 1; k >= 0; k--)
                if (en[k] && (t[k] > cyc)) code = 5'(k + 1);
        end
    endtask

    function automatic int rand_cyc();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return NEVER;
        if (r < 3) return int'($urandom_range(1900, 2100));
        return int'($urandom_range(0, 600));
    endfunction

    initial begin
        int  c_end;
        bit  got_done;
        bit  m_pass;
        int  m_cyc;
        logic [4:0] m_code;
        logic [1:0] m_seen;

        vecs[0] = '{3,     10,    20,    2'b11, 1'b0, 1'b1, 20,   5'd0, 2'b11};
        vecs[1] = '{NEVER, 5,     7,     2'b11, 1'b0, 1'b0, 1999, 5'd0, 2'b11};
        vecs[2] = '{3,     10,    NEVER, 2'b11, 1'b0, 1'b0, 1999, 5'd2, 2'b01};
        vecs[3] = '{3,     10,    NEVER, 2'b01, 1'b0, 1'b1, 10,   5'd0, 2'b01};
        vecs[4] = '{3,     1999,  5,     2'b11, 1'b0, 1'b1, 1999, 5'd0, 2'b11};
        vecs[5] = '{0,     NEVER, 0,     2'b11, 1'b1, 1'b1, 0,    5'd0, 2'b11};
        vecs[6] = '{2,     NEVER, NEVER, 2'b11, 1'b0, 1'b0, 1999, 5'd1, 2'b00};
        vecs[7] = '{7,     NEVER, NEVER, 2'b00, 1'b0, 1'b1, 7,    5'd0, 2'b00};

        i_rst_n  = 1'b0;
        i_start  = 1'b0;
        i_abort  = 1'b0;
        i_vld    = 1'b0;
        i_data   = '0;
        i_expect = '0;
        i_mask   = '0;
        i_en     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_dut_rst", 32'(o_dut_rst_n), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pass", 32'(o_pass), 32'd0);
        chk("rst_tick", 32'(o_tick), 32'd0);
        chk("rst_code", 32'(o_fail_code), 32'd0);
        chk("rst_seen", 32'(o_seen), 32'd0);
        chk("rst_cycles", o_cycles, 32'd0);
        i_rst_n = 1'b1;
        repeat (3) step();
        chk("idle_dut_rst", 32'(o_dut_rst_n), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Directed scenarios; each run restarts from the previous verdict.
        for (int i = 0; i < 8; i++) begin
            set_plan(vecs[i].v, vecs[i].t0, vecs[i].t1, vecs[i].en, vecs[i].zm0);
            start_run();
            run_to(TIMEOUT + 10, c_end, got_done);
            finish_check($sformatf("vec%0d", i), vecs[i].pass, vecs[i].cyc, vecs[i].code,
                         vecs[i].seen, c_end, got_done);
        end

        // Abort together with start at RUN cycle 50.
        set_plan(NEVER, 10, NEVER, 2'b11, 1'b0);
        start_run();
        run_to(50, c_end, got_done);
        chk("abort_no_early_done", 32'(got_done), 32'd0);
        drive_inputs(50);
        i_abort = 1'b1;
        i_start = 1'b1;
        step();
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_cycles", o_cycles, 32'd50);
        chk("abort_seen", 32'(o_seen), 32'd1);
        step();
        chk("abort_idle_busy", 32'(o_busy), 32'd0);
        chk("abort_idle_cycles", o_cycles, 32'd50);
        chk("abort_idle_tick", 32'(o_tick), 32'd0);

        // Reset in the middle of a run that would otherwise pass.
        set_plan(2, 5, 40, 2'b11, 1'b0);
        start_run();
        run_to(30, c_end, got_done);
        i_start = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_dut_rst", 32'(o_dut_rst_n), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_done", 32'(o_done), 32'd0);
        chk("midrst_pass", 32'(o_pass), 32'd0);
        chk("midrst_tick", 32'(o_tick), 32'd0);
        chk("midrst_code", 32'(o_fail_code), 32'd0);
        chk("midrst_seen", 32'(o_seen), 32'd0);
        chk("midrst_cycles", o_cycles, 32'd0);
        step();
        i_rst_n = 1'b1;
        repeat (50) step();
        chk("postrst_done", 32'(o_done), 32'd0);
        chk("postrst_busy", 32'(o_busy), 32'd0);
        chk("postrst_dut_rst", 32'(o_dut_rst_n), 32'd0);

        // Randomized runs against the reference model.
        for (int r = 0; r < 10; r++) begin
            set_plan(rand_cyc(), rand_cyc(), rand_cyc(), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0));
            model(p_v, p_t[0], p_t[1], i_en, m_pass, m_cyc, m_code, m_seen);
            start_run();
            run_to(TIMEOUT + 10, c_end, got_done);
            finish_check($sformatf("rnd%0d", r), m_pass, m_cyc, m_code, m_seen, c_end, got_done);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_io_checker
